// File: rtl/param_updown_counter_with_load.sv
// param_updown_counter_with_load: WIDTH-bit up/down counter driven by debounced buttons,
//   with level-sensitive parallel load, programmable STEP, and a wrap or saturate mode.
// Latency: counter, atMax, atMin and boundaryHit are registered. The counter changes at most
//   2**SCALER_BITS + 1 clocks after a synchronised button edge.
// Backpressure: none. Each press yields one request, held until the counter logic acks it.
// Ports:
//   systemClock, resetN (async, active-low)
//   upButton, downButton, loadButton  raw button inputs, synchronised internally
//   switches[WIDTH]                   load data
//   counter[WIDTH], atMax, atMin      registered count and boundary flags
//   boundaryHit                       1-cycle pulse when a wrap or clamp occurs
// Optional feature: define AUTO_REPEAT_EN for held-button auto repeat.
//   First repeat fires after 16 ticks, then one repeat every 4 ticks.
module param_updown_counter_with_load #(
  parameter int WIDTH       = 4,
  parameter int SCALER_BITS = 20,
  parameter int STEP        = 1,
  parameter int SATURATE    = 0
) (
  input  logic             systemClock,
  input  logic             resetN,
  input  logic             upButton,
  input  logic             downButton,
  input  logic             loadButton,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] counter,
  output logic             atMax,
  output logic             atMin,
  output logic             boundaryHit
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  localparam logic [WIDTH:0]       STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]       MAX_X  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0]     MAX_W  = {WIDTH{1'b1}};
  localparam logic [SCALER_BITS-1:0] PS_ONE = SCALER_BITS'(1);

  // Two-flop synchronisers. Bit 1 is the synchronised value.
  logic [1:0] up_sync_q, dn_sync_q, ld_sync_q;
  logic [SCALER_BITS-1:0] prescaler_q;
  logic tick;
  logic [1:0] btn_sync;   // [0] = up, [1] = down
  logic ld_sync;
  logic [1:0] req;
  logic [1:0] ack;

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             at_max_q, at_min_q, bhit_q, bhit_d;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] dif_w;

  always_ff @(posedge systemClock or negedge resetN) begin
    if (!resetN) begin
      up_sync_q   <= '0;
      dn_sync_q   <= '0;
      ld_sync_q   <= '0;
      prescaler_q <= '0;
    end else begin
      up_sync_q   <= {up_sync_q[0], upButton};
      dn_sync_q   <= {dn_sync_q[0], downButton};
      ld_sync_q   <= {ld_sync_q[0], loadButton};
      prescaler_q <= prescaler_q + PS_ONE;
    end
  end

  assign tick     = &prescaler_q;
  assign btn_sync = {dn_sync_q[1], up_sync_q[1]};
  assign ld_sync  = ld_sync_q[1];

  // Press detectors. A detector is disarmed after reset until it sees the button
  // released on a tick. A button still held through reset therefore cannot count
  // until it has been released and pressed again.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0] state_q, state_d;
    logic       armed_q, armed_d;
`ifdef AUTO_REPEAT_EN
    logic [3:0] rpt_q, rpt_d;
    logic       first_q, first_d;   // next repeat is the long initial delay
`endif

    always_comb begin
      state_d = state_q;
      armed_d = armed_q;
`ifdef AUTO_REPEAT_EN
      rpt_d   = rpt_q;
      first_d = first_q;
`endif
      if (tick && !btn_sync[b]) armed_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (tick && btn_sync[b] && armed_q) begin
            state_d = ST_REQ;
`ifdef AUTO_REPEAT_EN
            rpt_d   = 4'd0;
            first_d = 1'b1;
`endif
          end
        end
        ST_REQ: begin
          if (ack[b]) state_d = ST_WAIT_REL;
        end
        ST_WAIT_REL: begin
          if (tick && !btn_sync[b]) begin
            state_d = ST_IDLE;
          end
`ifdef AUTO_REPEAT_EN
          else if (tick) begin
            // Ticks held in WAIT_REL: the 16th re-requests first, then every 4th.
            if (rpt_q == (first_q ? 4'd15 : 4'd3)) begin
              state_d = ST_REQ;
              rpt_d   = 4'd0;
              first_d = 1'b0;
            end else begin
              rpt_d = rpt_q + 4'd1;
            end
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge systemClock or negedge resetN) begin
      if (!resetN) begin
        state_q <= ST_IDLE;
        armed_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_q   <= 4'd0;
        first_q <= 1'b1;
`endif
      end else begin
        state_q <= state_d;
        armed_q <= armed_d;
`ifdef AUTO_REPEAT_EN
        rpt_q   <= rpt_d;
        first_q <= first_d;
`endif
      end
    end

    assign req[b] = (state_q == ST_REQ);
  end

  assign sum_x = {1'b0, counter_q} + STEP_X;
  assign dif_w = counter_q - STEP_X[WIDTH-1:0];

  // Counter update and request acknowledgement.
  // Priority: load > simultaneous up/down > up > down.
  // Requests are discarded for as long as the synchronised load is high, not only
  // on the tick that loads. A press made together with a held load therefore
  // cannot count on the following clock.
  always_comb begin
    counter_d = counter_q;
    bhit_d    = 1'b0;
    ack       = 2'b00;
    if (ld_sync) begin
      ack = req;
      if (tick) counter_d = switches;
    end else if (&req) begin
      ack = 2'b11;
    end else if (req[0]) begin
      ack[0] = 1'b1;
      if (sum_x > MAX_X) begin
        bhit_d    = 1'b1;
        counter_d = (SATURATE != 0) ? MAX_W : sum_x[WIDTH-1:0];
      end else begin
        counter_d = sum_x[WIDTH-1:0];
      end
    end else if (req[1]) begin
      ack[1] = 1'b1;
      if ({1'b0, counter_q} < STEP_X) begin
        bhit_d    = 1'b1;
        counter_d = (SATURATE != 0) ? '0 : dif_w;
      end else begin
        counter_d = dif_w;
      end
    end
  end

  // Flags are computed from the next count, so they align with counter.
  always_ff @(posedge systemClock or negedge resetN) begin
    if (!resetN) begin
      counter_q <= '0;
      at_max_q  <= 1'b0;
      at_min_q  <= 1'b1;
      bhit_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      at_max_q  <= (counter_d == MAX_W);
      at_min_q  <= (counter_d == '0);
      bhit_q    <= bhit_d;
    end
  end

  assign counter     = counter_q;
  assign atMax       = at_max_q;
  assign atMin       = at_min_q;
  assign boundaryHit = bhit_q;

endmodule

// File: tb/tb_param_updown_counter_with_load.sv
// Testbench for param_updown_counter_with_load.
// Instance 0: SCALER_BITS=2, STEP=1, wrap mode. Instance 1: SCALER_BITS=2, STEP=3, saturate mode.
// Expected output changes are queued when stimulus is driven, then popped when a DUT output changes.
module tb_param_updown_counter_with_load;

  typedef enum int {OP_UP, OP_DN, OP_LD, OP_BOTH, OP_LDUP, OP_BOUNCE} op_e;

  typedef struct {
    op_e        op;
    int         inst;
    logic [3:0] sw;
    logic       ev;       // visible output event expected
    logic [3:0] exp_cnt;
    logic       exp_bh;   // boundaryHit in the cycle the new count appears
  } vec_t;

  typedef struct {
    int         inst;
    logic [3:0] cnt;
    logic       bh;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [1:0] up_b, dn_b, ld_b;
  logic [1:0][3:0] sw;
  logic [1:0][3:0] cnt;
  logic [1:0] amax, amin, bh;

  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 0;
  logic [1:0][3:0] prev;

  param_updown_counter_with_load #(.WIDTH(4), .SCALER_BITS(2), .STEP(1), .SATURATE(0)) dut0 (
    .systemClock(clk), .resetN(rst_n),
    .upButton(up_b[0]), .downButton(dn_b[0]), .loadButton(ld_b[0]),
    .switches(sw[0]), .counter(cnt[0]),
    .atMax(amax[0]), .atMin(amin[0]), .boundaryHit(bh[0])
  );

  param_updown_counter_with_load #(.WIDTH(4), .SCALER_BITS(2), .STEP(3), .SATURATE(1)) dut1 (
    .systemClock(clk), .resetN(rst_n),
    .upButton(up_b[1]), .downButton(dn_b[1]), .loadButton(ld_b[1]),
    .switches(sw[1]), .counter(cnt[1]),
    .atMax(amax[1]), .atMin(amin[1]), .boundaryHit(bh[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: each visible change, or boundaryHit pulse, must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (cnt[k] !== prev[k] || bh[k] !== 1'b0) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output inst%0d: counter=%0d boundaryHit=%0d, none expected",
                     k, cnt[k], bh[k]);
          end else begin
            e = sbq.pop_front();
            chk("sb_inst", k, e.inst);
            chk($sformatf("sb_counter_inst%0d", k), int'(cnt[k]), int'(e.cnt));
            chk($sformatf("sb_bhit_inst%0d", k), int'(bh[k]), int'(e.bh));
            chk($sformatf("sb_atMax_inst%0d", k), int'(amax[k]), int'(e.cnt == 4'hF));
            chk($sformatf("sb_atMin_inst%0d", k), int'(amin[k]), int'(e.cnt == 4'h0));
          end
          prev[k] = cnt[k];
        end
      end
    end
  end

  task automatic do_op(input int k, input op_e op, input logic [3:0] v);
    case (op)
      OP_UP: begin
        up_b[k] = 1'b1; repeat (10) @(negedge clk); up_b[k] = 1'b0;
      end
      OP_DN: begin
        dn_b[k] = 1'b1; repeat (10) @(negedge clk); dn_b[k] = 1'b0;
      end
      OP_BOTH: begin
        up_b[k] = 1'b1; dn_b[k] = 1'b1; repeat (10) @(negedge clk);
        up_b[k] = 1'b0; dn_b[k] = 1'b0;
      end
      OP_LD: begin
        sw[k] = v; ld_b[k] = 1'b1; repeat (6) @(negedge clk); ld_b[k] = 1'b0;
      end
      OP_LDUP: begin
        sw[k] = v; ld_b[k] = 1'b1; up_b[k] = 1'b1; repeat (10) @(negedge clk);
        ld_b[k] = 1'b0; up_b[k] = 1'b0;
      end
      OP_BOUNCE: begin
        // Five toggles within one clock period, then a long hold.
        up_b[k] = 1'b1; #2 up_b[k] = 1'b0; #2 up_b[k] = 1'b1;
        #2 up_b[k] = 1'b0; #2 up_b[k] = 1'b1;
        repeat (40) @(negedge clk);
        up_b[k] = 1'b0;
      end
      default: ;
    endcase
    repeat (10) @(negedge clk);
  endtask

  localparam int NV = 18;
  vec_t tbl[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{OP_BOUNCE, 0, 4'h0, 1'b1, 4'h1, 1'b0};
    tbl[1]  = '{OP_LD,     0, 4'hE, 1'b1, 4'hE, 1'b0};
    tbl[2]  = '{OP_UP,     0, 4'h0, 1'b1, 4'hF, 1'b0};
    tbl[3]  = '{OP_UP,     0, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[4]  = '{OP_DN,     0, 4'h0, 1'b1, 4'hF, 1'b1};
    tbl[5]  = '{OP_DN,     0, 4'h0, 1'b1, 4'hE, 1'b0};
    tbl[6]  = '{OP_BOTH,   0, 4'h0, 1'b0, 4'hE, 1'b0};
    tbl[7]  = '{OP_LDUP,   0, 4'h3, 1'b1, 4'h3, 1'b0};
    tbl[8]  = '{OP_UP,     0, 4'h0, 1'b1, 4'h4, 1'b0};
    tbl[9]  = '{OP_LD,     1, 4'h2, 1'b1, 4'h2, 1'b0};
    tbl[10] = '{OP_DN,     1, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[11] = '{OP_DN,     1, 4'h0, 1'b1, 4'h0, 1'b1};
    tbl[12] = '{OP_LD,     1, 4'hD, 1'b1, 4'hD, 1'b0};
    tbl[13] = '{OP_UP,     1, 4'h0, 1'b1, 4'hF, 1'b1};
    tbl[14] = '{OP_UP,     1, 4'h0, 1'b1, 4'hF, 1'b1};
    tbl[15] = '{OP_DN,     1, 4'h0, 1'b1, 4'hC, 1'b0};
    tbl[16] = '{OP_LD,     1, 4'h1, 1'b1, 4'h1, 1'b0};
    tbl[17] = '{OP_UP,     1, 4'h0, 1'b1, 4'h4, 1'b0};

    rst_n = 1'b1; up_b = '0; dn_b = '0; ld_b = '0; sw = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_counter_inst%0d", k), int'(cnt[k]), 0);
      chk($sformatf("reset_atMin_inst%0d", k), int'(amin[k]), 1);
      chk($sformatf("reset_atMax_inst%0d", k), int'(amax[k]), 0);
      chk($sformatf("reset_bhit_inst%0d", k), int'(bh[k]), 0);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    prev = cnt;
    mon_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].ev) sbq.push_back('{tbl[i].inst, tbl[i].exp_cnt, tbl[i].exp_bh});
      do_op(tbl[i].inst, tbl[i].op, tbl[i].sw);
      chk($sformatf("vec%0d_counter", i), int'(cnt[tbl[i].inst]), int'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_atMax", i), int'(amax[tbl[i].inst]), int'(tbl[i].exp_cnt == 4'hF));
      chk($sformatf("vec%0d_atMin", i), int'(amin[tbl[i].inst]), int'(tbl[i].exp_cnt == 4'h0));
      chk($sformatf("vec%0d_bhit_idle", i), int'(bh[tbl[i].inst]), 0);
    end

    // Async reset while the up button is held down.
    sbq.push_back('{0, 4'h5, 1'b0});
    up_b[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_count", int'(cnt[0]), 5);
    sbq.push_back('{0, 4'h0, 1'b0});
    sbq.push_back('{1, 4'h0, 1'b0});
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_counter0", int'(cnt[0]), 0);
    chk("async_reset_atMin0", int'(amin[0]), 1);
    chk("async_reset_counter1", int'(cnt[1]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("held_after_reset", int'(cnt[0]), 0);
    up_b[0] = 1'b0;
    repeat (10) @(negedge clk);
    sbq.push_back('{0, 4'h1, 1'b0});
    do_op(0, OP_UP, 4'h0);
    chk("repress_after_reset", int'(cnt[0]), 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
